bsg_router_crossbar_wormhole_o_by_i: RTL and testbench
======================================================

Name: bsg_router_crossbar_wormhole_o_by_i

Overview:
- Parametrised i_els_p x o_els_p crossbar for on-chip NoC routers, with a FIFO on every input.
- Per-flit one-hot output select plus last-flit marker.
- Each output has its own round-robin arbiter. A grant is held (wormhole locking) from a packet's first flit through its last flit, so multi-flit packets are never interleaved on an output.
- Successor to the single-flit o_by_i crossbar; used to chain local and network ports in mesh and ring routers.

Parameters:
- i_els_p, 2, number of input channels (>=1)
- o_els_p, 2, number of output channels (>=1)
- i_width_p, 10, flit payload width in bits
- fifo_els_p, 4, depth of each input FIFO (>=2)
- lock_en_p, 1, 1 = wormhole grant hold until last; 0 = re-arbitrate every flit (last_i ignored for arbitration)

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- valid_i  in  i_els_p  input flit valid
- data_i  in  i_els_p*i_width_p  input flit payload
- sel_i  in  i_els_p*o_els_p  one-hot destination output per input
- last_i  in  i_els_p  flit is the last of its packet (single-flit packet: 1)
- ready_and_o  out  i_els_p  input FIFO not full
- valid_o  out  o_els_p  output flit valid
- data_o  out  o_els_p*i_width_p  output payload
- last_o  out  o_els_p  last marker forwarded with the flit
- ready_and_i  in  o_els_p  downstream accepts

Behaviour:
- Reset: reset_n_i low asynchronously empties all FIFOs, clears all locks, and sets every round-robin pointer to input 0 (input 0 highest priority).
- During reset, ready_and_o=0 and valid_o=0. After release, ready_and_o=all-1s from the first edge.
- Enqueue: on valid_i[i] & ready_and_o[i], {last_i, sel_i, data_i} is written into FIFO i.
- ready_and_o[i] = ~full[i] only. It has no combinational dependence on dequeue, so a full FIFO refuses the flit even on a dequeue cycle.
- Latency: a flit enqueued at edge N can appear on valid_o at the earliest in cycle N+1, i.e. one cycle. valid_o/data_o/last_o are combinational from FIFO heads and arbiter state.
- Request: input i requests output o when FIFO i is non-empty and head.sel[o]=1. One-hot sel means an input requests at most one output per cycle.
- Per-output arbiter state machine, one per output:
  - UNLOCKED: grant = first requester at or after rr_ptr, wrapping modulo i_els_p.
    - valid_o[o] = any request. data_o/last_o come from the granted head.
    - On handshake (valid_o & ready_and_i): the granted FIFO dequeues and rr_ptr <= grant+1 (wrap to 0 past i_els_p-1).
    - If the head's last=0 and lock_en_p=1, go to LOCKED(owner=grant). Otherwise stay UNLOCKED.
  - LOCKED(owner): only owner may use the output.
    - valid_o[o] = owner requesting o. Other requests stall, and their FIFOs hold.
    - On handshake with last=1, go to UNLOCKED. rr_ptr was already advanced at packet start.
    - A lock persists indefinitely while the owner FIFO is empty (bubbles allowed mid-packet).
- valid_o is never retracted without a handshake while the grant is held: a higher-priority requester arriving while ready_and_i=0 in UNLOCKED does not change the grant.
  - Implement with a registered "pending" grant: once valid_o is presented un-accepted, the grant is frozen until handshake.
- Independent outputs transfer in the same cycle. Each input dequeues at most once per cycle.
- An input whose head targets a locked-by-other output blocks its own FIFO (head-of-line blocking; intended).
- sel_i not exactly one-hot while valid_i=1 is illegal. A simulation assertion fires; RTL behaviour is undefined.
- Reset mid-packet: all in-flight flits are discarded and locks are cleared. Downstream must tolerate a truncated packet.

Decomposition:
- Package bsg_router_xbar_pkg:
  - enum bsg_xbar_lock_e {e_unlocked, e_locked}
  - localparam for the default FIFO depth
  - function for wrap-around increment
- Sub-module bsg_rr_lock_arb:
  - one per output; i_els_p requests, handshake, last
  - outputs: grant one-hot, grant valid
  - contains rr_ptr, lock state, owner, and frozen-grant register
- FIFOs: the existing bsg_fifo_1r1w_small, width i_width_p+o_els_p+1.

Test Plan (i_els_p=2, o_els_p=2, i_width_p=10, fifo_els_p=4 unless stated):
1. Reset: hold reset_n_i low 3 cycles with valid_i=11 -> valid_o=00, ready_and_o=00. Release -> ready_and_o=11, no flit emitted.
2. Single flits, both inputs to output 0 every cycle, data 0x001 and 0x002, last=1, ready_and_i=11 -> data_o[0] alternates 0x001,0x002,... starting from input 0; valid_o[1]=0.
3. Wormhole: input 1 sends a 3-flit packet 0x100,0x101,0x102(last) to output 1, and input 0 sends 0x0AA to output 1 one cycle later -> output 1 shows 0x100,0x101,0x102 consecutively, then 0x0AA. Repeat with lock_en_p=0 -> flits interleave.
4. Backpressure: ready_and_i[0]=0 for 10 cycles while input 0 streams to output 0 -> 4 flits are accepted, then ready_and_o[0]=0. valid_o[0] stays 1 with the first flit and its data is stable. Release -> in-order drain with no loss or duplication.
5. Parallel paths: input 0 to output 1 and input 1 to output 0 concurrently -> both outputs carry a flit every cycle, 1-cycle latency each.
6. Mid-packet reset: assert reset_n_i between flit 1 and flit 2 of a 3-flit packet -> valid_o drops asynchronously. After release, output 1 arbitrates from input 0 and no stale flits appear.

Source files
------------

// File: rtl/bsg_router_xbar_pkg.sv
// Shared types and helpers for the wormhole o-by-i crossbar.
package bsg_router_xbar_pkg;

  typedef enum logic {
    e_unlocked,
    e_locked
  } bsg_xbar_lock_e;

  localparam int unsigned DefaultFifoEls = 4;

  // Advance an index by one and wrap back to zero past the last element.
  function automatic int unsigned wrapInc(input int unsigned cur, input int unsigned els);
    return ((cur + 32'd1) >= els) ? 32'd0 : (cur + 32'd1);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with valid/ready on the write side and
// valid/yumi on the read side. Full refuses writes even when a read happens
// in the same cycle, so ready_o depends on occupancy only.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int PtrW = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int CntW = $clog2(els_p + 1);

  logic [width_p-1:0] mem_q [els_p];
  logic [PtrW-1:0]    wrPtr_q, rdPtr_q;
  logic [CntW-1:0]    count_q;
  logic               enq, deq;

  assign ready_o = (count_q != CntW'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rdPtr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Storage needs no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wrPtr_q] <= data_i;
  end

  // Pointers and occupancy, cleared asynchronously so in-flight flits vanish.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (enq) wrPtr_q <= (wrPtr_q == PtrW'(els_p - 1)) ? '0 : wrPtr_q + 1'b1;
      if (deq) rdPtr_q <= (rdPtr_q == PtrW'(els_p - 1)) ? '0 : rdPtr_q + 1'b1;
      count_q <= count_q + CntW'(enq) - CntW'(deq);
    end
  end

endmodule

// File: rtl/bsg_router_crossbar_wormhole_o_by_i_arb.sv
// Per-output round-robin arbiter with wormhole locking and a frozen grant
// that keeps an offered-but-unaccepted flit on the output until it moves.
module bsg_rr_lock_arb
  import bsg_router_xbar_pkg::*;
#(
  parameter int els_p     = 2,
  parameter bit lock_en_p = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [els_p-1:0] reqs_i,
  input  logic             ready_i,
  input  logic             last_i,
  output logic [els_p-1:0] grants_o,
  output logic             v_o
);

  localparam int IdxW = (els_p > 1) ? $clog2(els_p) : 1;

  bsg_xbar_lock_e  lockState_q;
  logic [IdxW-1:0] rrPtr_q, owner_q, frozen_q;
  logic            pending_q;
  logic [IdxW-1:0] rrIdx, scanIdx, grantIdx;
  logic            rrFound;

  // Find the first requester at or after the round-robin pointer.
  always_comb begin
    rrFound = 1'b0;
    rrIdx   = '0;
    scanIdx = '0;
    for (int k = 0; k < els_p; k++) begin
      scanIdx = IdxW'((int'(rrPtr_q) + k) % els_p);
      if (!rrFound && reqs_i[scanIdx]) begin
        rrFound = 1'b1;
        rrIdx   = scanIdx;
      end
    end
  end

  // Lock owner wins, then a frozen pending grant, then the fresh scan.
  always_comb begin
    if (lockState_q == e_locked) begin
      grantIdx = owner_q;
      v_o      = reqs_i[owner_q];
    end else if (pending_q) begin
      grantIdx = frozen_q;
      v_o      = reqs_i[frozen_q];
    end else begin
      grantIdx = rrIdx;
      v_o      = rrFound;
    end
    grants_o           = '0;
    grants_o[grantIdx] = 1'b1;
  end

  // Lock state machine, pointer advance at packet start, grant freezing.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lockState_q <= e_unlocked;
      rrPtr_q     <= '0;
      owner_q     <= '0;
      frozen_q    <= '0;
      pending_q   <= 1'b0;
    end else if (v_o && ready_i) begin
      pending_q <= 1'b0;
      if (lockState_q == e_unlocked) begin
        rrPtr_q <= IdxW'(wrapInc(32'(grantIdx), els_p));
        if (lock_en_p && !last_i) begin
          lockState_q <= e_locked;
          owner_q     <= grantIdx;
        end
      end else if (last_i) begin
        lockState_q <= e_unlocked;
      end
    end else if (v_o && (lockState_q == e_unlocked)) begin
      pending_q <= 1'b1;
      frozen_q  <= grantIdx;
    end
  end

endmodule

// File: rtl/bsg_router_crossbar_wormhole_o_by_i.sv
// i_els_p x o_els_p wormhole crossbar: one FIFO per input, one locking
// round-robin arbiter per output, outputs combinational from FIFO heads.
module bsg_router_crossbar_wormhole_o_by_i
  import bsg_router_xbar_pkg::*;
#(
  parameter int i_els_p    = 2,
  parameter int o_els_p    = 2,
  parameter int i_width_p  = 10,
  parameter int fifo_els_p = DefaultFifoEls,
  parameter bit lock_en_p  = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [i_els_p-1:0]             valid_i,
  input  logic [i_els_p*i_width_p-1:0]   data_i,
  input  logic [i_els_p*o_els_p-1:0]     sel_i,
  input  logic [i_els_p-1:0]             last_i,
  output logic [i_els_p-1:0]             ready_and_o,
  output logic [o_els_p-1:0]             valid_o,
  output logic [o_els_p*i_width_p-1:0]   data_o,
  output logic [o_els_p-1:0]             last_o,
  input  logic [o_els_p-1:0]             ready_and_i
);

  localparam int FlitW = i_width_p + o_els_p + 1;

  logic [i_els_p-1:0]   fifoReady, fifoV, fifoYumi;
  logic [FlitW-1:0]     fifoHead [i_els_p];
  logic [i_width_p-1:0] headData [i_els_p];
  logic [o_els_p-1:0]   headSel  [i_els_p];
  logic [i_els_p-1:0]   headLast;
  logic [i_els_p-1:0]   reqs     [o_els_p];
  logic [i_els_p-1:0]   grants   [o_els_p];

  assign ready_and_o = fifoReady & {i_els_p{reset_n_i}};

  for (genvar i = 0; i < i_els_p; i++) begin : g_in
    bsg_fifo_1r1w_small #(
      .width_p(FlitW),
      .els_p  (fifo_els_p)
    ) fifo (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .v_i      (valid_i[i]),
      .ready_o  (fifoReady[i]),
      .data_i   ({last_i[i], sel_i[i*o_els_p +: o_els_p], data_i[i*i_width_p +: i_width_p]}),
      .v_o      (fifoV[i]),
      .data_o   (fifoHead[i]),
      .yumi_i   (fifoYumi[i])
    );
    assign {headLast[i], headSel[i], headData[i]} = fifoHead[i];
  end

  // Each non-empty input requests the single output its head flit selects.
  always_comb begin
    for (int o = 0; o < o_els_p; o++) begin
      for (int i = 0; i < i_els_p; i++) begin
        reqs[o][i] = fifoV[i] & headSel[i][o];
      end
    end
  end

  for (genvar o = 0; o < o_els_p; o++) begin : g_out
    bsg_rr_lock_arb #(
      .els_p    (i_els_p),
      .lock_en_p(lock_en_p)
    ) arb (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .reqs_i   (reqs[o]),
      .ready_i  (ready_and_i[o]),
      .last_i   (last_o[o]),
      .grants_o (grants[o]),
      .v_o      (valid_o[o])
    );
  end

  // Steer the granted head's payload and last marker onto each output.
  always_comb begin
    data_o = '0;
    last_o = '0;
    for (int o = 0; o < o_els_p; o++) begin
      for (int i = 0; i < i_els_p; i++) begin
        if (grants[o][i]) begin
          data_o[o*i_width_p +: i_width_p] = headData[i];
          last_o[o]                        = headLast[i];
        end
      end
    end
  end

  // Pop a FIFO when the output it holds the grant for completes a handshake.
  always_comb begin
    fifoYumi = '0;
    for (int o = 0; o < o_els_p; o++) begin
      fifoYumi = fifoYumi | (grants[o] & {i_els_p{valid_o[o] & ready_and_i[o]}});
    end
  end

  // Flag valid flits whose destination select is not exactly one-hot.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      for (int i = 0; i < i_els_p; i++) begin
        if (valid_i[i]) assert ($onehot(sel_i[i*o_els_p +: o_els_p]));
      end
    end
  end

endmodule

// File: tb/tb_bsg_router_crossbar_wormhole_o_by_i.sv
// Directed bench for the wormhole crossbar. Two copies share one stimulus:
// dutA locks packets, dutB re-arbitrates on every flit.
module tb_bsg_router_crossbar_wormhole_o_by_i;

  localparam logic [1:0] OUT0 = 2'b01;
  localparam logic [1:0] OUT1 = 2'b10;

  logic        clk;
  logic        resetN;
  logic [1:0]  validIn;
  logic [19:0] dataIn;
  logic [3:0]  selIn;
  logic [1:0]  lastIn;
  logic [1:0]  readyIn;

  logic [1:0]  readyOutA, validOutA, lastOutA;
  logic [19:0] dataOutA;
  logic [1:0]  readyOutB, validOutB, lastOutB;
  logic [19:0] dataOutB;

  int checks   = 0;
  int failures = 0;

  bsg_router_crossbar_wormhole_o_by_i #(
    .i_els_p(2), .o_els_p(2), .i_width_p(10), .fifo_els_p(4), .lock_en_p(1'b1)
  ) dutA (
    .clk_i(clk), .reset_n_i(resetN), .valid_i(validIn), .data_i(dataIn),
    .sel_i(selIn), .last_i(lastIn), .ready_and_o(readyOutA), .valid_o(validOutA),
    .data_o(dataOutA), .last_o(lastOutA), .ready_and_i(readyIn)
  );

  bsg_router_crossbar_wormhole_o_by_i #(
    .i_els_p(2), .o_els_p(2), .i_width_p(10), .fifo_els_p(4), .lock_en_p(1'b0)
  ) dutB (
    .clk_i(clk), .reset_n_i(resetN), .valid_i(validIn), .data_i(dataIn),
    .sel_i(selIn), .last_i(lastIn), .ready_and_o(readyOutB), .valid_o(validOutB),
    .data_o(dataOutB), .last_o(lastOutB), .ready_and_i(readyIn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [1:0] valid, input logic [9:0] d0, input logic [9:0] d1,
                               input logic [1:0] s0, input logic [1:0] s1,
                               input logic [1:0] last, input logic [1:0] rdy);
    validIn = valid;
    dataIn  = {d1, d0};
    selIn   = {s1, s0};
    lastIn  = last;
    readyIn = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held with traffic offered: nothing accepted, nothing emitted.
    resetN = 1'b0;
    applyStimulus(2'b11, 10'h001, 10'h002, OUT0, OUT0, 2'b11, 2'b11);
    repeat (3) tick();
    checkOutput("rst_validA", 32'(validOutA), 32'h0);
    checkOutput("rst_readyA", 32'(readyOutA), 32'h0);
    checkOutput("rst_validB", 32'(validOutB), 32'h0);
    resetN = 1'b1;
    applyStimulus(2'b00, 10'h000, 10'h000, OUT0, OUT0, 2'b11, 2'b11);
    #1;
    checkOutput("rel_readyA", 32'(readyOutA), 32'h3);
    checkOutput("rel_validA", 32'(validOutA), 32'h0);
    tick();
    checkOutput("rel_idle_validA", 32'(validOutA), 32'h0);
    $display("[TB] reset done");

    // Both inputs stream single flits to output 0; grant alternates from input 0.
    for (int k = 0; k < 7; k++) begin
      if (k < 3) applyStimulus(2'b11, 10'(1 + 2*k), 10'(2 + 2*k), OUT0, OUT0, 2'b11, 2'b11);
      else       applyStimulus(2'b00, 10'h000, 10'h000, OUT0, OUT0, 2'b11, 2'b11);
      tick();
      if (k < 6) begin
        checkOutput("rr_validA", 32'(validOutA), 32'h1);
        checkOutput("rr_dataA", 32'(dataOutA[9:0]), 32'(k + 1));
        checkOutput("rr_dataB", 32'(dataOutB[9:0]), 32'(k + 1));
      end else begin
        checkOutput("rr_drainedA", 32'(validOutA), 32'h0);
      end
    end

    // Wormhole: 3-flit packet from input 1 vs single flit from input 0 on output 1.
    applyStimulus(2'b10, 10'h000, 10'h100, OUT1, OUT1, 2'b00, 2'b11);
    tick();
    checkOutput("wh1_validA", 32'(validOutA), 32'h2);
    checkOutput("wh1_dataA", 32'(dataOutA[19:10]), 32'h100);
    checkOutput("wh1_lastA", 32'(lastOutA[1]), 32'h0);
    checkOutput("wh1_dataB", 32'(dataOutB[19:10]), 32'h100);
    applyStimulus(2'b11, 10'h0AA, 10'h101, OUT1, OUT1, 2'b01, 2'b11);
    tick();
    checkOutput("wh2_dataA", 32'(dataOutA[19:10]), 32'h101);
    checkOutput("wh2_lastA", 32'(lastOutA[1]), 32'h0);
    checkOutput("wh2_dataB", 32'(dataOutB[19:10]), 32'h0AA);
    checkOutput("wh2_lastB", 32'(lastOutB[1]), 32'h1);
    applyStimulus(2'b10, 10'h000, 10'h102, OUT1, OUT1, 2'b10, 2'b11);
    tick();
    checkOutput("wh3_dataA", 32'(dataOutA[19:10]), 32'h102);
    checkOutput("wh3_lastA", 32'(lastOutA[1]), 32'h1);
    checkOutput("wh3_dataB", 32'(dataOutB[19:10]), 32'h101);
    applyStimulus(2'b00, 10'h000, 10'h000, OUT1, OUT1, 2'b00, 2'b11);
    tick();
    checkOutput("wh4_validA", 32'(validOutA), 32'h2);
    checkOutput("wh4_dataA", 32'(dataOutA[19:10]), 32'h0AA);
    checkOutput("wh4_dataB", 32'(dataOutB[19:10]), 32'h102);
    tick();
    checkOutput("wh5_validA", 32'(validOutA), 32'h0);
    checkOutput("wh5_validB", 32'(validOutB), 32'h0);

    // Backpressure on output 0: FIFO fills to 4, head flit held steady.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(2'b01, 10'(16 + ((c < 4) ? c : 4)), 10'h000, OUT0, OUT0, 2'b11, 2'b10);
      tick();
      checkOutput("bp_validA", 32'(validOutA), 32'h1);
      checkOutput("bp_dataA", 32'(dataOutA[9:0]), 32'h010);
      checkOutput("bp_readyA", 32'(readyOutA[0]), 32'(c < 3));
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 2)      applyStimulus(2'b01, 10'h014, 10'h000, OUT0, OUT0, 2'b11, 2'b11);
      else if (k < 3) applyStimulus(2'b01, 10'h015, 10'h000, OUT0, OUT0, 2'b11, 2'b11);
      else            applyStimulus(2'b00, 10'h000, 10'h000, OUT0, OUT0, 2'b11, 2'b11);
      tick();
      if (k < 5) begin
        checkOutput("drain_dataA", 32'(dataOutA[9:0]), 32'(17 + k));
        checkOutput("drain_dataB", 32'(dataOutB[9:0]), 32'(17 + k));
      end else begin
        checkOutput("drain_doneA", 32'(validOutA), 32'h0);
      end
    end

    // Stalled grant stays frozen when a higher-priority input shows up.
    applyStimulus(2'b01, 10'h0A1, 10'h000, OUT0, OUT0, 2'b11, 2'b10);
    tick();
    checkOutput("frz1_dataA", 32'(dataOutA[9:0]), 32'h0A1);
    applyStimulus(2'b10, 10'h000, 10'h0B1, OUT0, OUT0, 2'b11, 2'b10);
    tick();
    checkOutput("frz2_dataA", 32'(dataOutA[9:0]), 32'h0A1);
    applyStimulus(2'b00, 10'h000, 10'h000, OUT0, OUT0, 2'b11, 2'b10);
    tick();
    checkOutput("frz3_dataA", 32'(dataOutA[9:0]), 32'h0A1);
    checkOutput("frz3_dataB", 32'(dataOutB[9:0]), 32'h0A1);
    applyStimulus(2'b00, 10'h000, 10'h000, OUT0, OUT0, 2'b11, 2'b11);
    tick();
    checkOutput("frz4_dataA", 32'(dataOutA[9:0]), 32'h0B1);
    tick();
    checkOutput("frz5_validA", 32'(validOutA), 32'h0);

    // Crossed paths run concurrently with one-cycle latency.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) applyStimulus(2'b11, 10'(8'h50 + k), 10'(8'h60 + k), OUT1, OUT0, 2'b11, 2'b11);
      else       applyStimulus(2'b00, 10'h000, 10'h000, OUT1, OUT0, 2'b11, 2'b11);
      tick();
      if (k < 3) begin
        checkOutput("par_validA", 32'(validOutA), 32'h3);
        checkOutput("par_out0A", 32'(dataOutA[9:0]), 32'(8'h60 + k));
        checkOutput("par_out1A", 32'(dataOutA[19:10]), 32'(8'h50 + k));
      end else begin
        checkOutput("par_doneA", 32'(validOutA), 32'h0);
      end
    end

    // Reset in the middle of a packet drops flits and clears the lock.
    applyStimulus(2'b10, 10'h000, 10'h300, OUT1, OUT1, 2'b00, 2'b11);
    tick();
    checkOutput("mr1_dataA", 32'(dataOutA[19:10]), 32'h300);
    applyStimulus(2'b10, 10'h000, 10'h301, OUT1, OUT1, 2'b00, 2'b11);
    tick();
    checkOutput("mr2_dataA", 32'(dataOutA[19:10]), 32'h301);
    resetN = 1'b0;
    applyStimulus(2'b00, 10'h000, 10'h000, OUT1, OUT1, 2'b00, 2'b11);
    #1;
    checkOutput("mr_async_validA", 32'(validOutA), 32'h0);
    checkOutput("mr_async_readyA", 32'(readyOutA), 32'h0);
    checkOutput("mr_async_validB", 32'(validOutB), 32'h0);
    repeat (2) tick();
    resetN = 1'b1;
    #1;
    checkOutput("mr_rel_readyA", 32'(readyOutA), 32'h3);
    checkOutput("mr_rel_validA", 32'(validOutA), 32'h0);
    applyStimulus(2'b11, 10'h0C0, 10'h0C1, OUT1, OUT1, 2'b11, 2'b11);
    tick();
    checkOutput("mr3_validA", 32'(validOutA), 32'h2);
    checkOutput("mr3_dataA", 32'(dataOutA[19:10]), 32'h0C0);
    applyStimulus(2'b00, 10'h000, 10'h000, OUT1, OUT1, 2'b11, 2'b11);
    tick();
    checkOutput("mr4_dataA", 32'(dataOutA[19:10]), 32'h0C1);
    tick();
    checkOutput("mr5_validA", 32'(validOutA), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
